// File: rtl/uart_cmd_rx.sv
// rtl/uart_cmd_rx.sv - 8N1 UART receiver with 4-byte write-command decoder for trigger config
module uart_cmd_rx #(
    parameter int          CLKS_PER_BIT = 434,
    parameter int          TIMEOUT_CLKS = 50000,
    parameter logic [7:0]  SYNC_BYTE    = 8'h53,
    parameter logic [13:0] THRESH_RST   = 14'd9000
) (
    input  logic        clk_50,
    input  logic        reset,
    input  logic        UART_RX,
    output logic [7:0]  rx_byte,
    output logic        rx_valid,
    output logic        frame_err,
    output logic [13:0] trig_threshold,
    output logic [13:0] trig_holdoff,
    output logic        trig_slope,
    output logic        force_arm,
    output logic        cmd_ok,
    output logic        cmd_err
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int TW = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CLKS - 1);

    typedef enum logic [2:0] {B_IDLE, B_START, B_DATA, B_STOP, B_BREAK} bit_state_t;
    typedef enum logic [1:0] {P_SYNC, P_ADDR, P_DHI, P_DLO} parse_state_t;

    bit_state_t   b_state, b_next;
    parse_state_t p_state, p_next;

    logic          rx_meta, rx_sync, rx_prev;
    logic [CW-1:0] bcnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          cnt_clr, shift_en, byte_ok, byte_bad;

    logic [TW-1:0] tcnt;
    logic [7:0]    addr_q, dhi_q;
    logic [15:0]   cmd_data;
    logic          lat_addr, lat_dhi, wr_thr, wr_hold, wr_slope, ok_set, err_set, fire_set;

    // rx_prev provides the falling-edge reference for start-bit detection
    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= UART_RX;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) b_state <= B_IDLE;
        else       b_state <= b_next;
    end

    always_comb begin
        b_next   = b_state;
        cnt_clr  = 1'b0;
        shift_en = 1'b0;
        byte_ok  = 1'b0;
        byte_bad = 1'b0;
        case (b_state)
            B_IDLE: if (rx_prev && !rx_sync) begin
                b_next  = B_START;
                cnt_clr = 1'b1;
            end
            B_START: if (bcnt == HALF_LAST) begin
                cnt_clr = 1'b1;
                b_next  = rx_sync ? B_IDLE : B_DATA;
            end
            B_DATA: if (bcnt == BIT_LAST) begin
                cnt_clr  = 1'b1;
                shift_en = 1'b1;
                if (bit_idx == 3'd7) b_next = B_STOP;
            end
            B_STOP: if (bcnt == BIT_LAST) begin
                cnt_clr = 1'b1;
                if (rx_sync) begin
                    byte_ok = 1'b1;
                    b_next  = B_IDLE;
                end else begin
                    byte_bad = 1'b1;
                    b_next   = B_BREAK;
                end
            end
            B_BREAK: if (rx_sync) b_next = B_IDLE;
            default: b_next = B_IDLE;
        endcase
    end

    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            bcnt      <= '0;
            bit_idx   <= 3'd0;
            shreg     <= 8'd0;
            rx_byte   <= 8'd0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            bcnt      <= cnt_clr ? '0 : bcnt + CW'(1);
            bit_idx   <= (b_state == B_START) ? 3'd0 : (shift_en ? bit_idx + 3'd1 : bit_idx);
            if (shift_en) shreg <= {rx_sync, shreg[7:1]};
            if (byte_ok) rx_byte <= shreg;
            rx_valid  <= byte_ok;
            frame_err <= byte_bad;
        end
    end

    assign cmd_data = {dhi_q, rx_byte};

    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) p_state <= P_SYNC;
        else       p_state <= p_next;
    end

    always_comb begin
        p_next   = p_state;
        lat_addr = 1'b0;
        lat_dhi  = 1'b0;
        wr_thr   = 1'b0;
        wr_hold  = 1'b0;
        wr_slope = 1'b0;
        ok_set   = 1'b0;
        err_set  = 1'b0;
        fire_set = 1'b0;
        if (rx_valid) begin
            case (p_state)
                P_SYNC: if (rx_byte == SYNC_BYTE) p_next = P_ADDR;
                P_ADDR: begin
                    lat_addr = 1'b1;
                    p_next   = P_DHI;
                end
                P_DHI: begin
                    lat_dhi = 1'b1;
                    p_next  = P_DLO;
                end
                default: begin
                    p_next = P_SYNC;
                    case (addr_q)
                        8'h00: if (cmd_data[15:14] == 2'b00) begin wr_thr = 1'b1; ok_set = 1'b1; end
                               else err_set = 1'b1;
                        8'h01: if (cmd_data[15:14] == 2'b00) begin wr_hold = 1'b1; ok_set = 1'b1; end
                               else err_set = 1'b1;
                        8'h02: if (cmd_data[15:1] == 15'd0) begin wr_slope = 1'b1; ok_set = 1'b1; end
                               else err_set = 1'b1;
                        8'h03: begin fire_set = 1'b1; ok_set = 1'b1; end
                        default: err_set = 1'b1;
                    endcase
                end
            endcase
        end else if (p_state != P_SYNC && (frame_err || tcnt == TO_LAST)) begin
            // a broken byte or a stalled host abandons the partial command
            err_set = 1'b1;
            p_next  = P_SYNC;
        end
    end

    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            tcnt           <= '0;
            addr_q         <= 8'd0;
            dhi_q          <= 8'd0;
            trig_threshold <= THRESH_RST;
            trig_holdoff   <= 14'd0;
            trig_slope     <= 1'b0;
            force_arm      <= 1'b0;
            cmd_ok         <= 1'b0;
            cmd_err        <= 1'b0;
        end else begin
            tcnt      <= (rx_valid || p_state == P_SYNC) ? '0 : tcnt + TW'(1);
            if (lat_addr) addr_q <= rx_byte;
            if (lat_dhi)  dhi_q  <= rx_byte;
            if (wr_thr)   trig_threshold <= cmd_data[13:0];
            if (wr_hold)  trig_holdoff   <= cmd_data[13:0];
            if (wr_slope) trig_slope     <= cmd_data[0];
            force_arm <= fire_set;
            cmd_ok    <= ok_set;
            cmd_err   <= err_set;
        end
    end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// tb/tb_uart_cmd_rx.sv - self-checking bench for uart_cmd_rx with vector table and command model
module tb_uart_cmd_rx;

    localparam int CPB = 8;
    localparam int TMO = 200;

    logic        clk_50 = 1'b0;
    logic        reset;
    logic        UART_RX;
    logic [7:0]  rx_byte;
    logic        rx_valid, frame_err, trig_slope, force_arm, cmd_ok, cmd_err;
    logic [13:0] trig_threshold, trig_holdoff;

    uart_cmd_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TMO), .SYNC_BYTE(8'h53), .THRESH_RST(14'd9000)) dut (
        .clk_50(clk_50), .reset(reset), .UART_RX(UART_RX),
        .rx_byte(rx_byte), .rx_valid(rx_valid), .frame_err(frame_err),
        .trig_threshold(trig_threshold), .trig_holdoff(trig_holdoff), .trig_slope(trig_slope),
        .force_arm(force_arm), .cmd_ok(cmd_ok), .cmd_err(cmd_err)
    );

    always #10 clk_50 = ~clk_50;

    int n_cmp = 0, n_bad = 0;
    int n_valid = 0, n_ferr = 0, n_ok = 0, n_err = 0, n_force = 0, n_fo = 0, n_falone = 0;
    logic [7:0] got_q[$];
    logic [7:0] sent_q[$];

    always @(negedge clk_50) begin
        if (!reset) begin
            if (rx_valid) begin n_valid++; got_q.push_back(rx_byte); end
            if (frame_err) n_ferr++;
            if (cmd_ok) n_ok++;
            if (cmd_err) n_err++;
            if (force_arm) n_force++;
            if (force_arm && cmd_ok) n_fo++;
            if (force_arm && !cmd_ok) n_falone++;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_50);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_lvl);
        UART_RX = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            UART_RX = b[i];
            idle(CPB);
        end
        UART_RX = stop_lvl;
        idle(CPB);
        if (stop_lvl) sent_q.push_back(b);
    endtask

    task automatic send_frame(input logic [31:0] f);
        for (int i = 3; i >= 0; i--) begin
            send_byte(f[i*8 +: 8], 1'b1);
            idle(2);
        end
        idle(10);
    endtask

    task automatic check_echo(input string name);
        int bad;
        bad = 0;
        chk({name, "_count"}, got_q.size(), sent_q.size());
        for (int i = 0; i < got_q.size() && i < sent_q.size(); i++)
            if (got_q[i] != sent_q[i]) bad++;
        chk({name, "_bytes"}, bad, 0);
        got_q.delete();
        sent_q.delete();
    endtask

    // reference command model: byte stream in, register state and pulse counts out
    int m_thr, m_hold, m_slope, m_ok, m_err, m_force;
    int pend[$];

    function automatic void model_exec(input int addr, input int data);
        case (addr)
            0: if (data < 16384) begin m_thr = data; m_ok++; end else m_err++;
            1: if (data < 16384) begin m_hold = data; m_ok++; end else m_err++;
            2: if (data < 2) begin m_slope = data; m_ok++; end else m_err++;
            3: begin m_ok++; m_force++; end
            default: m_err++;
        endcase
    endfunction

    function automatic void model_byte(input int b);
        if (pend.size() == 0 && b != 8'h53) return;
        pend.push_back(b);
        if (pend.size() == 4) begin
            model_exec(pend[1], pend[2] * 256 + pend[3]);
            pend.delete();
        end
    endfunction

    typedef struct {
        logic [31:0] frame;
        int thr, hold, slope, ok, err, frc;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int ok0, err0, frc0, fe0, v0;
        logic [7:0] junk, addr, dhi, dlo;
        logic [31:0] fr;

        vecs[0]  = '{32'h53002328, 9000, 0,     0, 1, 0, 0};
        vecs[1]  = '{32'h53001F40, 8000, 0,     0, 1, 0, 0};
        vecs[2]  = '{32'h53014000, 8000, 0,     0, 0, 1, 0};
        vecs[3]  = '{32'h53070000, 8000, 0,     0, 0, 1, 0};
        vecs[4]  = '{32'h53013FFF, 8000, 16383, 0, 1, 0, 0};
        vecs[5]  = '{32'h53020002, 8000, 16383, 0, 0, 1, 0};
        vecs[6]  = '{32'h53028001, 8000, 16383, 0, 0, 1, 0};
        vecs[7]  = '{32'h5300C000, 8000, 16383, 0, 0, 1, 0};
        vecs[8]  = '{32'h53031234, 8000, 16383, 0, 1, 0, 1};
        vecs[9]  = '{32'h53020001, 8000, 16383, 1, 1, 0, 0};
        vecs[10] = '{32'h53020000, 8000, 16383, 0, 1, 0, 0};
        vecs[11] = '{32'h53000053, 83,   16383, 0, 1, 0, 0};

        reset = 1'b1;
        UART_RX = 1'b1;
        idle(3);
        chk("rst_rx_byte", rx_byte, 0);
        chk("rst_threshold", trig_threshold, 9000);
        chk("rst_holdoff", trig_holdoff, 0);
        chk("rst_slope", trig_slope, 0);
        chk("rst_pulses", {rx_valid, frame_err, force_arm, cmd_ok, cmd_err}, 0);
        reset = 1'b0;
        idle(5);

        foreach (vecs[k]) begin
            ok0 = n_ok; err0 = n_err; frc0 = n_force;
            send_frame(vecs[k].frame);
            chk($sformatf("v%0d_threshold", k), trig_threshold, vecs[k].thr);
            chk($sformatf("v%0d_holdoff", k), trig_holdoff, vecs[k].hold);
            chk($sformatf("v%0d_slope", k), trig_slope, vecs[k].slope);
            chk($sformatf("v%0d_cmd_ok", k), n_ok - ok0, vecs[k].ok);
            chk($sformatf("v%0d_cmd_err", k), n_err - err0, vecs[k].err);
            chk($sformatf("v%0d_force", k), n_force - frc0, vecs[k].frc);
        end
        check_echo("table_echo");

        // stop bit low, line held in break, then recovery
        fe0 = n_ferr; v0 = n_valid; err0 = n_err; ok0 = n_ok;
        send_byte(8'hA5, 1'b0);
        idle(3 * CPB);
        UART_RX = 1'b1;
        idle(20);
        chk("ferr_pulse", n_ferr - fe0, 1);
        chk("ferr_no_valid", n_valid - v0, 0);
        chk("ferr_no_cmd_err", n_err - err0, 0);
        send_frame(32'h53020001);
        chk("ferr_slope", trig_slope, 1);
        chk("ferr_cmd_ok", n_ok - ok0, 1);

        // quarter-bit glitch on idle line
        fe0 = n_ferr; v0 = n_valid;
        UART_RX = 1'b0;
        idle(CPB / 4);
        UART_RX = 1'b1;
        idle(20);
        chk("glitch_no_valid", n_valid - v0, 0);
        chk("glitch_no_ferr", n_ferr - fe0, 0);
        send_byte(8'h55, 1'b1);
        idle(10);
        chk("glitch_next_valid", n_valid - v0, 1);
        chk("glitch_next_byte", rx_byte, 8'h55);
        check_echo("glitch_echo");

        // inter-byte timeout
        err0 = n_err; ok0 = n_ok; frc0 = n_force;
        send_byte(8'h53, 1'b1);
        idle(2);
        send_byte(8'h03, 1'b1);
        idle(150);
        chk("tmo_not_early", n_err - err0, 0);
        idle(100);
        chk("tmo_cmd_err", n_err - err0, 1);
        chk("tmo_no_ok", n_ok - ok0, 0);
        err0 = n_err; v0 = n_fo;
        send_frame(32'h53030000);
        chk("arm_cmd_ok", n_ok - ok0, 1);
        chk("arm_force", n_force - frc0, 1);
        chk("arm_same_cycle", n_fo - v0, 1);
        chk("arm_no_err", n_err - err0, 0);
        check_echo("tmo_echo");

        // randomized command stream against the model
        m_thr = 83; m_hold = 16383; m_slope = 1;
        m_ok = n_ok; m_err = n_err; m_force = n_force;
        for (int f = 0; f < 25; f++) begin
            if ($urandom_range(0, 3) == 0) begin
                junk = 8'($urandom_range(0, 255));
                if (junk == 8'h53) junk = 8'h00;
                send_byte(junk, 1'b1);
                model_byte(junk);
                idle($urandom_range(0, 6));
            end
            addr = 8'($urandom_range(0, 4));
            if (addr == 8'd4) addr = 8'($urandom_range(4, 255));
            dhi = 8'($urandom_range(0, 255));
            dlo = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) begin
                if (addr < 8'd2) dhi = dhi & 8'h3F;
                if (addr == 8'd2) begin dhi = 8'h00; dlo = dlo & 8'h01; end
            end
            if ($urandom_range(0, 7) == 0) dlo = 8'h53;
            fr = {8'h53, addr, dhi, dlo};
            for (int i = 3; i >= 0; i--) begin
                send_byte(fr[i*8 +: 8], 1'b1);
                model_byte(int'(fr[i*8 +: 8]));
                idle($urandom_range(0, 6));
            end
            idle(10);
            chk($sformatf("rnd%0d_threshold", f), trig_threshold, m_thr);
            chk($sformatf("rnd%0d_holdoff", f), trig_holdoff, m_hold);
            chk($sformatf("rnd%0d_slope", f), trig_slope, m_slope);
        end
        chk("rnd_cmd_ok", n_ok, m_ok);
        chk("rnd_cmd_err", n_err, m_err);
        chk("rnd_force", n_force, m_force);
        check_echo("rnd_echo");

        // reset in the middle of a threshold write
        send_frame(32'h530004D2);
        send_frame(32'h5301004D);
        send_frame(32'h53020001);
        chk("pre_rst_threshold", trig_threshold, 1234);
        send_byte(8'h53, 1'b1);
        idle(2);
        send_byte(8'h00, 1'b1);
        idle(2);
        UART_RX = 1'b0;
        idle(3 * CPB);
        reset = 1'b1;
        UART_RX = 1'b1;
        idle(2);
        chk("mid_rst_rx_byte", rx_byte, 0);
        chk("mid_rst_threshold", trig_threshold, 9000);
        chk("mid_rst_holdoff", trig_holdoff, 0);
        chk("mid_rst_slope", trig_slope, 0);
        chk("mid_rst_pulses", {rx_valid, frame_err, force_arm, cmd_ok, cmd_err}, 0);
        reset = 1'b0;
        idle(10);
        got_q.delete();
        sent_q.delete();
        ok0 = n_ok; err0 = n_err;
        send_frame(32'h5301002A);
        chk("post_rst_holdoff", trig_holdoff, 42);
        chk("post_rst_threshold", trig_threshold, 9000);
        chk("post_rst_cmd_ok", n_ok - ok0, 1);
        chk("post_rst_cmd_err", n_err - err0, 0);
        check_echo("post_rst_echo");
        chk("force_without_ok", n_falone, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
